// File: rtl/video_modulator_chroma_mixer_if.sv
// Sample/sideband bundle between the modulator front end and the chroma mixer.
// The master drives stage-0 operands, the delayed products and the stats clear; the slave returns the mixed sample.
interface video_modulator_chroma_mixer_if;
    logic        valid_in;
    logic        sign_u;
    logic        sign_v;
    logic [7:0]  luma_8;
    logic        blank;
    logic        burst;
    logic        burst_neg;
    logic [15:0] product_u_16;
    logic [15:0] product_v_16;
    logic        clr_stats;
    logic        valid_out;
    logic [8:0]  chroma_9;
    logic [7:0]  composite_8;
    logic [15:0] clip_count;

    modport master (
        output valid_in, sign_u, sign_v, luma_8, blank, burst, burst_neg,
               product_u_16, product_v_16, clr_stats,
        input  valid_out, chroma_9, composite_8, clip_count
    );

    modport slave (
        input  valid_in, sign_u, sign_v, luma_8, blank, burst, burst_neg,
               product_u_16, product_v_16, clr_stats,
        output valid_out, chroma_9, composite_8, clip_count
    );
endinterface

// File: rtl/video_modulator_chroma_mixer.sv
// Chroma mixer: re-signs the magnitude products, sums/scales chroma, adds luma and clamps to 8 bits.
// Optional 2-tap chroma averaging is enabled with VIDEO_MODULATOR_CHROMA_LPF_EN.
module video_modulator_chroma_mixer #(
    parameter int unsigned CHROMA_SHIFT = 2,
    parameter logic [8:0]  BURST_AMP    = 9'd40
) (
    input logic                          clk,
    input logic                          rst,
    video_modulator_chroma_mixer_if.slave bus
);

    localparam logic signed [11:0] BURST_P = $signed({3'b000, BURST_AMP});
    localparam logic signed [11:0] BURST_N = -BURST_P;

    // Stage 1: sidebands wait one cycle for the multiplier products
    logic       v1, su1, sv1, blank1, burst1, bneg1;
    logic [7:0] luma1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            su1    <= 1'b0;
            sv1    <= 1'b0;
            blank1 <= 1'b0;
            burst1 <= 1'b0;
            bneg1  <= 1'b0;
            luma1  <= 8'd0;
        end else begin
            v1     <= bus.valid_in;
            su1    <= bus.sign_u;
            sv1    <= bus.sign_v;
            blank1 <= bus.blank;
            burst1 <= bus.burst;
            bneg1  <= bus.burst_neg;
            luma1  <= bus.luma_8;
        end
    end

    logic [8:0]         mag_u, mag_v;
    logic signed [9:0]  term_u, term_v;
    logic signed [10:0] sum_d;
    logic               unused_lsbs;

    assign mag_u       = bus.product_u_16[15:7];
    assign mag_v       = bus.product_v_16[15:7];
    assign unused_lsbs = ^{bus.product_u_16[6:0], bus.product_v_16[6:0]};

    always_comb begin
        term_u = su1 ? -$signed({1'b0, mag_u}) : $signed({1'b0, mag_u});
        term_v = sv1 ? -$signed({1'b0, mag_v}) : $signed({1'b0, mag_v});
        sum_d  = $signed({term_u[9], term_u}) + $signed({term_v[9], term_v});
    end

    // Stage 2: signed sum plus sidebands
    logic               v2, blank2, burst2, bneg2;
    logic [7:0]         luma2;
    logic signed [10:0] sum2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            blank2 <= 1'b0;
            burst2 <= 1'b0;
            bneg2  <= 1'b0;
            luma2  <= 8'd0;
            sum2   <= 11'sd0;
        end else begin
            v2     <= v1;
            blank2 <= blank1;
            burst2 <= burst1;
            bneg2  <= bneg1;
            luma2  <= luma1;
            sum2   <= sum_d;
        end
    end

    logic signed [11:0] c_pre;

`ifdef VIDEO_MODULATOR_CHROMA_LPF_EN
    logic signed [10:0] sum_prev;
    logic signed [11:0] sum_pair;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_prev <= 11'sd0;
        end else if (v2) begin
            sum_prev <= sum2;
        end
    end

    // Pair sum needs 12 bits; the extra shift turns it into an average
    always_comb begin
        sum_pair = $signed({sum2[10], sum2}) + $signed({sum_prev[10], sum_prev});
        c_pre    = sum_pair >>> (CHROMA_SHIFT + 1);
    end
`else
    always_comb begin
        c_pre = $signed({sum2[10], sum2}) >>> CHROMA_SHIFT;
    end
`endif

    logic signed [11:0] c_fin, y;
    logic               clip_lo, clip_hi, clip;
    logic [7:0]         comp_d;

    always_comb begin
        if (blank2 && burst2) begin
            c_fin = bneg2 ? BURST_N : BURST_P;
        end else if (blank2) begin
            c_fin = 12'sd0;
        end else begin
            c_fin = c_pre;
        end
        y       = $signed({4'b0000, luma2}) + c_fin;
        clip_lo = y[11];
        clip_hi = ~y[11] & (|y[10:8]);
        clip    = clip_lo | clip_hi;
        if (clip_lo) begin
            comp_d = 8'h00;
        end else if (clip_hi) begin
            comp_d = 8'hFF;
        end else begin
            comp_d = y[7:0];
        end
    end

    // Stage 3: outputs hold their last valid sample through bubbles
    logic        valid_q;
    logic [8:0]  chroma_q;
    logic [7:0]  composite_q;
    logic [15:0] clip_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            chroma_q    <= 9'd0;
            composite_q <= 8'd0;
        end else begin
            valid_q <= v2;
            if (v2) begin
                chroma_q    <= c_fin[8:0];
                composite_q <= comp_d;
            end
        end
    end

    // Clear has priority over a coincident clip event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_q <= 16'd0;
        end else if (bus.clr_stats) begin
            clip_q <= 16'd0;
        end else if (v2 && clip && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.chroma_9    = chroma_q;
    assign bus.composite_8 = composite_q;
    assign bus.clip_count  = clip_q;

endmodule

// File: tb/tb_video_modulator_chroma_mixer.sv
// Directed bench for the chroma mixer (default build, CHROMA_SHIFT=2, BURST_AMP=40).
module tb_video_modulator_chroma_mixer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_modulator_chroma_mixer_if bus ();

    video_modulator_chroma_mixer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic        su;
        logic        sv;
        logic [7:0]  luma;
        logic        blank;
        logic        burst;
        logic        bneg;
        logic [15:0] pu;
        logic [15:0] pv;
        logic [8:0]  e_chroma;
        logic [7:0]  e_comp;
        logic        e_clip;
    } vec_t;

    localparam int N = 13;
    vec_t vecs [N];
    vec_t vclip;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive_stage0(input vec_t x);
        bus.valid_in  = x.v;
        bus.sign_u    = x.su;
        bus.sign_v    = x.sv;
        bus.luma_8    = x.luma;
        bus.blank     = x.blank;
        bus.burst     = x.burst;
        bus.burst_neg = x.bneg;
    endtask

    task automatic drive_idle0();
        bus.valid_in  = 1'b0;
        bus.sign_u    = 1'b0;
        bus.sign_v    = 1'b0;
        bus.luma_8    = 8'd0;
        bus.blank     = 1'b0;
        bus.burst     = 1'b0;
        bus.burst_neg = 1'b0;
    endtask

    task automatic drive_products(input logic [15:0] pu, input logic [15:0] pv);
        bus.product_u_16 = pu;
        bus.product_v_16 = pv;
    endtask

    logic [15:0] exp_cnt;
    logic [8:0]  last_chroma;
    logic [7:0]  last_comp;

    initial begin
        //            v     su    sv    luma    blank burst bneg  pu        pv        chroma   comp    clip
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 9'd32,   8'd160, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 16'h4000, 16'h2000, 9'h1F0,  8'd0,   1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd64,  1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 9'h1D8,  8'd24,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd64,  1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 9'd0,    8'd64,  1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'hAA,  1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 9'd0,    8'd0,   1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'd200, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h4321, 9'd40,   8'd240, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd100, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h1000, 9'd24,   8'd124, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd250, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 9'd255,  8'd255, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'd64,  1'b0, 1'b0, 1'b0, 16'h7F80, 16'h0080, 9'h1C0,  8'd0,   1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 9'h1FF,  8'd0,   1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 9'd0,    8'd255, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd77,  1'b0, 1'b0, 1'b0, 16'h007F, 16'h00FF, 9'd0,    8'd77,  1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 9'd1,    8'd255, 1'b1};
        vclip    = '{1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 16'h0080, 16'h0000, 9'h1FF,  8'd0,   1'b1};

        rst           = 1'b1;
        bus.clr_stats = 1'b0;
        drive_idle0();
        drive_products(16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_out",   {31'd0, bus.valid_out}, 32'd0);
        check("reset chroma_9",    {23'd0, bus.chroma_9},  32'd0);
        check("reset composite_8", {24'd0, bus.composite_8}, 32'd0);
        check("reset clip_count",  {16'd0, bus.clip_count}, 32'd0);
        rst = 1'b0;

        // Back-to-back stream with a bubble in slot 4
        exp_cnt     = 16'd0;
        last_chroma = 9'd0;
        last_comp   = 8'd0;
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk);
            #1;
            if (c >= 3) begin
                check($sformatf("vec%0d valid_out", c - 3), {31'd0, bus.valid_out}, {31'd0, vecs[c-3].v});
                if (vecs[c-3].v) begin
                    if (vecs[c-3].e_clip) exp_cnt = exp_cnt + 16'd1;
                    last_chroma = vecs[c-3].e_chroma;
                    last_comp   = vecs[c-3].e_comp;
                    check($sformatf("vec%0d clip_count", c - 3), {16'd0, bus.clip_count}, {16'd0, exp_cnt});
                end
                check($sformatf("vec%0d chroma_9", c - 3),    {23'd0, bus.chroma_9},    {23'd0, last_chroma});
                check($sformatf("vec%0d composite_8", c - 3), {24'd0, bus.composite_8}, {24'd0, last_comp});
            end
            if (c < N) drive_stage0(vecs[c]);
            else drive_idle0();
            if (c >= 1 && c <= N) drive_products(vecs[c-1].pu, vecs[c-1].pv);
            else drive_products(16'h0000, 16'h0000);
        end

        // Continuous clipping from a cleared count up to saturation
        bus.clr_stats = 1'b1;
        drive_stage0(vclip);
        drive_products(vclip.pu, vclip.pv);
        @(posedge clk);
        #1;
        bus.clr_stats = 1'b0;
        check("clear count", {16'd0, bus.clip_count}, 32'd0);
        repeat (65540) @(posedge clk);
        #1;
        check("saturate reach", {16'd0, bus.clip_count}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("saturate hold", {16'd0, bus.clip_count}, 32'h0000FFFF);
        check("clip chroma_9", {23'd0, bus.chroma_9}, {23'd0, vclip.e_chroma});
        check("clip composite_8", {24'd0, bus.composite_8}, {24'd0, vclip.e_comp});

        // Clear coinciding with a clip event
        bus.clr_stats = 1'b1;
        @(posedge clk);
        #1;
        check("clear beats clip", {16'd0, bus.clip_count}, 32'd0);
        bus.clr_stats = 1'b0;
        @(posedge clk);
        #1;
        check("count after clear", {16'd0, bus.clip_count}, 32'd1);

        // Asynchronous reset with samples in flight; inputs stay valid while held
        #3;
        rst = 1'b1;
        #1;
        check("midreset valid_out",   {31'd0, bus.valid_out},   32'd0);
        check("midreset chroma_9",    {23'd0, bus.chroma_9},    32'd0);
        check("midreset composite_8", {24'd0, bus.composite_8}, 32'd0);
        check("midreset clip_count",  {16'd0, bus.clip_count},  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle0();
        drive_products(16'h0000, 16'h0000);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset idle%0d valid_out", c), {31'd0, bus.valid_out}, 32'd0);
        end

        // First sample after reset emerges exactly three cycles later
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c >= 1) begin
                check($sformatf("post-reset cyc%0d valid_out", c), {31'd0, bus.valid_out}, {31'd0, (c == 3)});
            end
            if (c == 3) begin
                check("post-reset chroma_9",    {23'd0, bus.chroma_9},    32'd32);
                check("post-reset composite_8", {24'd0, bus.composite_8}, 32'd160);
                check("post-reset clip_count",  {16'd0, bus.clip_count},  32'd0);
            end
            if (c == 0) drive_stage0(vecs[0]);
            else drive_idle0();
            if (c == 1) drive_products(vecs[0].pu, vecs[0].pv);
            else drive_products(16'h0000, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
